// File: rtl/line_sum_hex_if.sv
// Byte-stream bundle for line_sum_hex: received ASCII bytes in, hex result bytes out
// with a busy back-pressure signal, plus the error and drop counters.
interface line_sum_hex_if #(
    parameter int CNT_W = 8
);
    logic             input_valid;
    logic [7:0]       input_data;
    logic             output_busy;
    logic             output_en;
    logic [7:0]       output_data;
    logic [CNT_W-1:0] error_count;
    logic [CNT_W-1:0] drop_count;

    modport slave (
        input  input_valid, input_data, output_busy,
        output output_en, output_data, error_count, drop_count
    );

    modport master (
        output input_valid, input_data, output_busy,
        input  output_en, output_data, error_count, drop_count
    );
endinterface

// File: rtl/line_sum_hex.sv
// Sums the comma/space separated decimal numbers of each text line and answers
// with the total as hex without leading zeros, or "E" for a line with bad bytes.
module line_sum_hex #(
    parameter int WIDTH     = 32,
    parameter bit UPPERCASE = 1'b0,
    parameter int CNT_W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    line_sum_hex_if.slave bus
);
    typedef enum logic [1:0] {PARSE, SKIP, DIGITS, NEWLINE} state_t;

    localparam int                 NIB      = WIDTH / 4;
    localparam int                 REM_W    = $clog2(NIB + 1);
    localparam logic [REM_W-1:0]   REM_FULL = REM_W'(NIB);
    localparam logic [REM_W-1:0]   REM_ONE  = REM_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    state_t           r_state;
    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_shift;
    logic             r_err;
    logic             r_pending;
    logic [REM_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_errCnt;
    logic [CNT_W-1:0] r_dropCnt;
    logic             r_outEn;
    logic [7:0]       r_outData;

    logic             w_isDigit;
    logic             w_isSep;
    logic [WIDTH-1:0] w_digitVal;
    logic [WIDTH-1:0] w_curNext;
    logic [WIDTH-1:0] w_lineVal;
    logic [WIDTH-1:0] w_shifted;
    logic [3:0]       w_topNib;
    logic [3:0]       w_nextNib;
    logic             w_xfer;

    function automatic logic [7:0] hexChar(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    assign w_isDigit  = (bus.input_data >= 8'h30) && (bus.input_data <= 8'h39);
    assign w_isSep    = (bus.input_data == 8'h20) || (bus.input_data == 8'h2C);
    assign w_digitVal = WIDTH'(bus.input_data[3:0]);
    assign w_curNext  = (r_cur << 3) + (r_cur << 1) + w_digitVal;
    assign w_lineVal  = r_sum + r_cur;
    assign w_shifted  = {r_shift[WIDTH-5:0], 4'h0};
    assign w_topNib   = r_shift[WIDTH-1 -: 4];
    assign w_nextNib  = r_shift[WIDTH-5 -: 4];
    assign w_xfer     = r_outEn && !bus.output_busy;

    // Outputs are registered; the reset gate keeps the bus quiet in the reset cycle itself.
    assign bus.output_en   = r_outEn && !rst;
    assign bus.output_data = rst ? 8'h00 : r_outData;
    assign bus.error_count = r_errCnt;
    assign bus.drop_count  = r_dropCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= PARSE;
            r_cur       <= '0;
            r_sum       <= '0;
            r_shift     <= '0;
            r_err       <= 1'b0;
            r_pending   <= 1'b0;
            r_remaining <= '0;
            r_errCnt    <= '0;
            r_dropCnt   <= '0;
            r_outEn     <= 1'b0;
            r_outData   <= 8'h00;
        end else begin
            if (bus.input_valid && r_state != PARSE && r_dropCnt != CNT_MAX)
                r_dropCnt <= r_dropCnt + CNT_ONE;

            case (r_state)
                PARSE: begin
                    if (bus.input_valid) begin
                        if (w_isDigit) begin
                            r_cur <= w_curNext;
                        end else if (w_isSep) begin
                            r_sum <= w_lineVal;
                            r_cur <= '0;
                        end else if (bus.input_data == 8'h0D) begin
                            r_cur <= r_cur;
                        end else if (bus.input_data == 8'h0A) begin
                            r_cur <= '0;
                            r_sum <= '0;
                            r_err <= 1'b0;
                            if (r_err) begin
                                r_state   <= NEWLINE;
                                r_pending <= 1'b1;
                                r_outEn   <= 1'b1;
                                r_outData <= 8'h45;
                                if (r_errCnt != CNT_MAX)
                                    r_errCnt <= r_errCnt + CNT_ONE;
                            end else begin
                                r_shift     <= w_lineVal;
                                r_remaining <= REM_FULL;
                                r_state     <= SKIP;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                // Strip leading zero nibbles, always keeping the last one so zero prints "0".
                SKIP: begin
                    if (w_topNib == 4'h0 && r_remaining > REM_ONE) begin
                        r_shift     <= w_shifted;
                        r_remaining <= r_remaining - REM_ONE;
                    end else begin
                        r_state   <= DIGITS;
                        r_outEn   <= 1'b1;
                        r_outData <= hexChar(w_topNib);
                    end
                end
                DIGITS: begin
                    if (w_xfer) begin
                        r_shift     <= w_shifted;
                        r_remaining <= r_remaining - REM_ONE;
                        if (r_remaining == REM_ONE) begin
                            r_state   <= NEWLINE;
                            r_outData <= 8'h0A;
                        end else begin
                            r_outData <= hexChar(w_nextNib);
                        end
                    end
                end
                NEWLINE: begin
                    if (w_xfer) begin
                        if (r_pending) begin
                            r_pending <= 1'b0;
                            r_outData <= 8'h0A;
                        end else begin
                            r_state   <= PARSE;
                            r_outEn   <= 1'b0;
                            r_outData <= 8'h00;
                        end
                    end
                end
                default: r_state <= PARSE;
            endcase
        end
    end
endmodule

// File: doc/line_sum_hex.md
LINE_SUM_HEX -- requirements
Module: line_sum_hex

Interface
REQ-001 SHALL take parameter WIDTH, default 32: accumulator width in bits; a multiple of 4, range 8..64.
REQ-002 SHALL take parameter UPPERCASE, default 0: 1 emits hex digits "A".."F", 0 emits "a".."f".
REQ-003 SHALL take parameter CNT_W, default 8: width of the error and drop counters.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port input_valid, input, 1 bit: input_data holds a received byte this cycle.
REQ-007 SHALL have port input_data, input, 8 bits: received ASCII byte.
REQ-008 SHALL have port output_busy, input, 1 bit: the sink cannot accept a byte this cycle.
REQ-009 SHALL have port output_en, output, 1 bit: output_data is presented for transfer.
REQ-010 SHALL have port output_data, output, 8 bits: ASCII byte to send.
REQ-011 SHALL have port error_count, output, CNT_W bits: saturating count of lines that contained an illegal byte.
REQ-012 SHALL have port drop_count, output, CNT_W bits: saturating count of input bytes dropped while not in PARSE.

Function
REQ-013 SHALL transfer one output byte in each cycle where output_en=1 and output_busy=0; no other cycle transfers.
REQ-014 SHALL hold output_data stable while output_en=1 and output_busy=1.
REQ-015 SHALL implement states PARSE, SKIP, DIGITS and NEWLINE; the state after reset is PARSE.
REQ-016 In PARSE, on digit "0".."9": cur <= cur*10 + digit, modulo 2^WIDTH (silent wrap).
REQ-017 In PARSE, on " " or ",": sum <= sum + cur (mod 2^WIDTH), then cur <= 0; repeated separators add 0.
REQ-018 In PARSE, "\r" SHALL be ignored with no state change.
REQ-019 In PARSE, any other byte except "\n" SHALL set the line err flag; parsing of later digits continues but has no effect on the result.
REQ-020 In PARSE, on "\n" with err=0: load shift register with sum+cur, load remaining <= WIDTH/4, and go to SKIP.
REQ-021 In PARSE, on "\n" with err=1: go to NEWLINE with a pending "E" byte, and increment error_count, saturating.
REQ-022 On every "\n", cur, sum and err SHALL clear in the same cycle.
REQ-023 In SKIP (output_en=0): if the top nibble is 0 and remaining>1, shift left 4 and decrement remaining by one per cycle; otherwise go to DIGITS.
REQ-024 Result: leading zeros are suppressed; value 0 emits the single digit "0".
REQ-025 In DIGITS: output_en=1 and output_data = ASCII hex of the top nibble.
REQ-026 In DIGITS, on each transfer: shift left 4 and decrement remaining; after the transfer of the last digit, go to NEWLINE.
REQ-027 In NEWLINE: output_en=1 and output_data = "E" if pending, else "\n".
REQ-028 In NEWLINE, on transfer of "E": clear pending and stay in NEWLINE; on transfer of "\n": go to PARSE.
REQ-029 input_valid in SKIP, DIGITS or NEWLINE SHALL drop the byte without parsing it, and increment drop_count, saturating.
REQ-030 Latency: first output byte presented no later than WIDTH/4+1 cycles after the cycle in which "\n" is received.
REQ-031 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-032 In PARSE, output_en SHALL be 0.

Reset
REQ-033 While rst=1: state <= PARSE; cur, sum, err, pending, remaining, shift register, error_count and drop_count SHALL all be 0.
REQ-034 During rst=1 and in the cycle after: output_en=0 and output_data=0.
REQ-035 Reset asserted mid-transmission SHALL abort the line immediately; no further bytes of it are emitted and input_valid is ignored during reset.

Verification
REQ-036 "12 30\n", busy=0 -> bytes "2","a","\n"; counters stay 0.
REQ-037 "\n", then "4294967295\n", then "4294967296\n" (WIDTH=32) -> "0\n", "ffffffff\n", "0\n".
REQ-038 "1x2\n" -> "E\n"; error_count=1; a following "7\n" -> "7\n".
REQ-039 UPPERCASE=1, "255,\r\n", busy high 3 cycles per byte -> "FF\n"; output_data stable while busy=1; no byte is duplicated or lost.
REQ-040 "65535\n" then 3 bytes sent during DIGITS -> "ffff\n"; drop_count=3.
REQ-041 rst pulsed after the first digit of "ffff" is sent -> output_en=0 next cycle; a following "1\n" -> "1\n".
